// File: rtl/os_inst_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// os_seq_pkg
// Shared definitions for the output-stationary instruction sequencer:
//   - bit positions of every field in the 40-bit core instruction word
//   - the instruction word driven while idle / in reset (INST_RST)
//   - default tile geometry and base addresses
//   - sequencer state encoding and the {mode, execute, load} control bundle
//   - build_inst(): assembles a full instruction word from its variable fields
// ----------------------------------------------------------------------------
package os_seq_pkg;

   localparam int INST_W = 40;

   // Instruction field positions
   localparam int INST_PSUM_BYPASS = 39;
   localparam int INST_ACC         = 38;
   localparam int INST_CEN_PMEM    = 37;
   localparam int INST_WEN_PMEM    = 36;
   localparam int INST_A_PMEM_MSB  = 35;
   localparam int INST_A_PMEM_LSB  = 27;
   localparam int INST_CEN1        = 26;
   localparam int INST_A1_MSB      = 25;
   localparam int INST_A1_LSB      = 18;
   localparam int INST_CEN0        = 17;
   localparam int INST_WEN0        = 16;
   localparam int INST_A0_MSB      = 15;
   localparam int INST_A0_LSB      = 8;
   localparam int INST_OFIFO_RD    = 7;
   localparam int INST_IFIFO_WR    = 6;
   localparam int INST_IFIFO_RD    = 5;
   localparam int INST_L0_RD       = 4;
   localparam int INST_L0_WR       = 3;
   localparam int INST_MODE        = 2;
   localparam int INST_EXECUTE     = 1;
   localparam int INST_LOAD        = 0;

   // All memory enables / write enables inactive (high), everything else 0
   localparam logic [INST_W-1:0] INST_RST = 40'h30_0403_0000;

   // Default tile geometry
   localparam int         LEN_NIJ_DEF   = 27;
   localparam int         SHIFT_LEN_DEF = 16;
   localparam int         N_OUT_DEF     = 8;
   localparam int         PIPE_DLY_DEF  = 3;
   localparam logic [7:0] ACT_BASE_DEF  = 8'h00;
   localparam logic [7:0] W_BASE_DEF    = 8'h80;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXEC  = 3'd1,
      SHIFT = 3'd2,
      FLUSH = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_e;

   typedef struct packed {
      logic mode;
      logic execute;
      logic load;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE  = '{mode: 1'b0, execute: 1'b0, load: 1'b0};
   localparam ctrl_t CTRL_EXEC  = '{mode: 1'b1, execute: 1'b1, load: 1'b0};
   localparam ctrl_t CTRL_SHIFT = '{mode: 1'b1, execute: 1'b0, load: 1'b1};

   // Start from the reset word so the fixed fields (pmem controls, WEN0,
   // psum_bypass, acc) can never be disturbed by the sequencer.
   function automatic logic [INST_W-1:0] build_inst(
      input logic       issue,
      input logic [7:0] a1,
      input logic [7:0] a0,
      input logic [4:0] fifo,
      input ctrl_t      ctrl
   );
      logic [INST_W-1:0] w;
      w                              = INST_RST;
      w[INST_CEN1]                   = ~issue;
      w[INST_A1_MSB:INST_A1_LSB]     = a1;
      w[INST_CEN0]                   = ~issue;
      w[INST_A0_MSB:INST_A0_LSB]     = a0;
      w[INST_OFIFO_RD:INST_L0_WR]    = fifo;
      w[INST_MODE]                   = ctrl.mode;
      w[INST_EXECUTE]                = ctrl.execute;
      w[INST_LOAD]                   = ctrl.load;
      return w;
   endfunction

endpackage

// File: rtl/os_inst_sequencer_delay_line.sv
// ----------------------------------------------------------------------------
// os_delay_line
// Fixed-depth shift register for the {mode, execute, load} control bundle.
// Ports:
//   clk    in  rising-edge clock
//   clr_n  in  asynchronous active-low clear
//   din    in  control bundle entering the line
//   dout   out control bundle delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module os_delay_line
   import os_seq_pkg::*;
#(
   parameter int DEPTH = PIPE_DLY_DEF
) (
   input  logic  clk,
   input  logic  clr_n,
   input  ctrl_t din,
   output ctrl_t dout
);

   ctrl_t stage_r [DEPTH];

   // Shift the control bundle one stage per cycle
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= CTRL_NONE;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/os_inst_sequencer.sv
// ----------------------------------------------------------------------------
// os_inst_sequencer
// Drives the core instruction bus for one output-stationary tile:
//   EXEC  : stream LEN_NIJ activation/weight pairs from xmem when both L0 and
//           IFIFO are ready, with write/read/execute following each issue
//   SHIFT : SHIFT_LEN cycles of mode=1/load=1 (psum shift-out)
//   FLUSH : PIPE_DLY idle cycles so the control delay line empties
//   DRAIN : read N_OUT rows from the OFIFO, one per observed ofifo_valid
//   DONE  : single-cycle done pulse, then back to IDLE
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begins a tile when idle
//   l0_ready     in   L0 can accept a row
//   ififo_ready  in   IFIFO can accept a row
//   ofifo_valid  in   OFIFO holds a readable row
//   inst         out  40-bit instruction word to core (registered)
//   busy         out  tile in progress (registered)
//   done         out  one-cycle completion pulse (registered)
// ----------------------------------------------------------------------------
module os_inst_sequencer
   import os_seq_pkg::*;
#(
   parameter int         LEN_NIJ   = LEN_NIJ_DEF,
   parameter int         SHIFT_LEN = SHIFT_LEN_DEF,
   parameter int         N_OUT     = N_OUT_DEF,
   parameter logic [7:0] ACT_BASE  = ACT_BASE_DEF,
   parameter logic [7:0] W_BASE    = W_BASE_DEF,
   parameter int         PIPE_DLY  = PIPE_DLY_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              l0_ready,
   input  logic              ififo_ready,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done
);

   // Terminal counts; LEN_NIJ must not exceed 128 so the 8-bit index is exact
   localparam logic [7:0] LAST_IDX   = 8'(LEN_NIJ - 1);
   localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_LEN - 1);
   localparam logic [7:0] FLUSH_LAST = 8'(PIPE_DLY - 1);
   localparam logic [7:0] N_OUT_CNT  = 8'(N_OUT);

   state_e            state_r;
   state_e            state_s;
   logic [7:0]        issue_idx_r;
   logic [7:0]        issue_idx_s;
   logic [7:0]        phase_cnt_r;
   logic [7:0]        phase_cnt_s;
   logic [7:0]        rd_cnt_r;
   logic [7:0]        rd_cnt_s;
   logic              issue_q1_r;
   logic              issue_q2_r;
   logic              issue_s;
   logic              ofifo_rd_s;
   ctrl_t             dec_s;
   ctrl_t             dly_s;
   logic [7:0]        a0_s;
   logic [7:0]        a1_s;
   logic [INST_W-1:0] inst_r;
   logic [INST_W-1:0] inst_s;
   logic              busy_r;
   logic              done_r;

   // The control bundle is decoded alongside the issue decision; the delay
   // line plus the inst register place it PIPE_DLY cycles after the issue.
   os_delay_line #(
      .DEPTH (PIPE_DLY)
   ) u_dly (
      .clk   (clk),
      .clr_n (reset),
      .din   (dec_s),
      .dout  (dly_s)
   );

   // Next-state, counter and decode logic
   always_comb begin
      state_s     = state_r;
      issue_idx_s = issue_idx_r;
      phase_cnt_s = phase_cnt_r;
      rd_cnt_s    = rd_cnt_r;
      issue_s     = 1'b0;
      ofifo_rd_s  = 1'b0;
      dec_s       = CTRL_NONE;

      case (state_r)
         IDLE: begin
            if (start) begin
               state_s     = EXEC;
               issue_idx_s = 8'd0;
               phase_cnt_s = 8'd0;
               rd_cnt_s    = 8'd0;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if (l0_ready && ififo_ready) begin
               issue_s     = 1'b1;
               dec_s       = CTRL_EXEC;
               issue_idx_s = issue_idx_r + 8'd1;
               if (issue_idx_r == LAST_IDX) begin
                  state_s     = SHIFT;
                  phase_cnt_s = 8'd0;
               end else begin
                  state_s = EXEC;
               end
            end else begin
               state_s = EXEC;
            end
         end
         SHIFT: begin
            dec_s = CTRL_SHIFT;
            if (phase_cnt_r == SHIFT_LAST) begin
               state_s     = FLUSH;
               phase_cnt_s = 8'd0;
            end else begin
               phase_cnt_s = phase_cnt_r + 8'd1;
            end
         end
         FLUSH: begin
            if (phase_cnt_r == FLUSH_LAST) begin
               state_s  = DRAIN;
               rd_cnt_s = 8'd0;
            end else begin
               phase_cnt_s = phase_cnt_r + 8'd1;
            end
         end
         DRAIN: begin
            // Read count is checked before valid so no read can exceed N_OUT
            if (rd_cnt_r == N_OUT_CNT) begin
               state_s = DONE;
            end else if (ofifo_valid) begin
               ofifo_rd_s = 1'b1;
               rd_cnt_s   = rd_cnt_r + 8'd1;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            state_s     = IDLE;
            issue_idx_s = 8'd0;
            phase_cnt_s = 8'd0;
            rd_cnt_s    = 8'd0;
         end
         default: begin
            state_s     = IDLE;
            issue_idx_s = 8'd0;
            phase_cnt_s = 8'd0;
            rd_cnt_s    = 8'd0;
         end
      endcase

      // Addresses advance only on an issue and otherwise hold their last value
      if (issue_s) begin
         a0_s = ACT_BASE + issue_idx_r;
         a1_s = W_BASE + issue_idx_r;
      end else begin
         a0_s = inst_r[INST_A0_MSB:INST_A0_LSB];
         a1_s = inst_r[INST_A1_MSB:INST_A1_LSB];
      end

      // fifo field order: {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr}
      inst_s = build_inst(issue_s, a1_s, a0_s,
                          {ofifo_rd_s, issue_q1_r, issue_q2_r, issue_q2_r, issue_q1_r},
                          dly_s);
   end

   // State, counters and the issue taps that time the FIFO write/read strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         issue_idx_r <= 8'd0;
         phase_cnt_r <= 8'd0;
         rd_cnt_r    <= 8'd0;
         issue_q1_r  <= 1'b0;
         issue_q2_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         issue_idx_r <= issue_idx_s;
         phase_cnt_r <= phase_cnt_s;
         rd_cnt_r    <= rd_cnt_s;
         issue_q1_r  <= issue_s;
         issue_q2_r  <= issue_q1_r;
      end
   end

   // Registered outputs; busy drops in the cycle done is raised
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_r <= INST_RST;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         inst_r <= inst_s;
         busy_r <= (state_s != IDLE) && (state_s != DONE);
         done_r <= (state_s == DONE);
      end
   end

   assign inst = inst_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule
